mcp3008_responder: RTL and testbench

- Synthesizable SPI responder that emulates an MCP3008 10-bit, 8-channel ADC.
- Answers the same start/SGL/D2..D0 command frame our SPI ADC master issues, returning 10-bit codes taken from an on-chip sample bus.
- Sits between an SPI master, on-chip or looped out through pins, and internal sample sources. Used for hardware-in-loop bring-up and regression of the ADC path without a physical chip.
- All logic runs on CLK50. SCLK, CS_n and SPI_IN are oversampled, not used as clocks.

---
 rtl/mcp3008_responder_if.sv | 25 ++
 rtl/mcp3008_responder.sv | 220 ++++++++++++++++++++++
 tb/tb_mcp3008_responder.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mcp3008_responder_if.sv
// Pin-level SPI bundle between an ADC master and the MCP3008 responder.
// The master drives clock, select and DIN; the responder drives DOUT and its pad enable.
interface mcp3008_responder_if;
    logic SCLK;
    logic CS_n;
    logic SPI_IN;
    logic SPI_OUT;
    logic SPI_OE;

    modport master (
        output SCLK,
        output CS_n,
        output SPI_IN,
        input  SPI_OUT,
        input  SPI_OE
    );

    modport slave (
        input  SCLK,
        input  CS_n,
        input  SPI_IN,
        output SPI_OUT,
        output SPI_OE
    );
endinterface

// File: rtl/mcp3008_responder.sv
// MCP3008-compatible SPI responder: decodes start/SGL/D2..D0 on oversampled SPI pins
// and shifts back a 10-bit code taken from the on-chip sample bus.
module mcp3008_responder #(
    parameter int CHANNELS    = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                     CLK50,
    input  logic                     reset,
    mcp3008_responder_if.slave       spi,
    input  logic [CHANNELS-1:0][9:0] adc_in,
    output logic                     req_valid,
    output logic [2:0]               req_chan,
    output logic                     req_sgl,
    output logic                     abort
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_START,
        S_CMD,
        S_SAMPLE,
        S_SHIFT,
        S_DONE
    } state_t;

    // Channel index check against the number of emulated channels.
    function automatic logic idx_valid(input logic [2:0] idx);
        return int'(idx) < CHANNELS;
    endfunction

    function automatic logic [9:0] chan_value(input logic [CHANNELS-1:0][9:0] bus,
                                              input logic [2:0]               idx);
        logic [9:0] v;
        v = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (idx == 3'(i)) v = bus[i];
        end
        return v;
    endfunction

    // Negative differences clamp to zero; the sign is taken from the 11-bit result.
    function automatic logic [9:0] clamp_diff(input logic [9:0] pos, input logic [9:0] neg);
        logic signed [10:0] diff;
        diff = signed'({1'b0, pos}) - signed'({1'b0, neg});
        return diff[10] ? 10'd0 : diff[9:0];
    endfunction

    function automatic logic [9:0] conv_result(input logic [CHANNELS-1:0][9:0] bus,
                                               input logic                     sgl,
                                               input logic [2:0]               d);
        logic [2:0] neg_idx;
        logic [9:0] r;
        neg_idx = {d[2:1], ~d[0]};
        r       = '0;
        if (sgl) begin
            if (idx_valid(d)) r = chan_value(bus, d);
        end else if (idx_valid(d) && idx_valid(neg_idx)) begin
            r = clamp_diff(chan_value(bus, d), chan_value(bus, neg_idx));
        end
        return r;
    endfunction

    // Input synchronizers and edge detection (stage p0 = synchronized, p1 = one cycle older)
    logic [SYNC_STAGES-1:0] sclk_sync, csn_sync, din_sync;
    logic sclk_p0, csn_p0, din_p0;
    logic sclk_p1, csn_p1;
    logic sclk_rise, sclk_fall, cs_fall, cs_rise;

    always_ff @(posedge CLK50) begin
        if (reset) begin
            sclk_sync <= '0;
            csn_sync  <= '0;
            din_sync  <= '0;
            sclk_p1   <= 1'b0;
            csn_p1    <= 1'b0;
        end else begin
            sclk_sync <= (sclk_sync << 1) | SYNC_STAGES'(spi.SCLK);
            csn_sync  <= (csn_sync << 1) | SYNC_STAGES'(spi.CS_n);
            din_sync  <= (din_sync << 1) | SYNC_STAGES'(spi.SPI_IN);
            sclk_p1   <= sclk_p0;
            csn_p1    <= csn_p0;
        end
    end

    assign sclk_p0   = sclk_sync[SYNC_STAGES-1];
    assign csn_p0    = csn_sync[SYNC_STAGES-1];
    assign din_p0    = din_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_p0 & ~sclk_p1;
    assign sclk_fall = ~sclk_p0 & sclk_p1;
    // A fall needs a high level seen first, so a reset inside a frame waits for the next select.
    assign cs_fall   = ~csn_p0 & csn_p1;
    assign cs_rise   = csn_p0 & ~csn_p1;

    // Frame state machine
    state_t     state_q, state_d;
    logic [2:0] k_q, k_d;
    logic [3:0] bit_q, bit_d;
    logic [3:0] cmd_q, cmd_d;
    logic [9:0] sr_q, sr_d;
    logic       spi_out_q, spi_out_d;
    logic       spi_oe_q, spi_oe_d;
    logic       req_valid_q, req_valid_d;
    logic [2:0] req_chan_q, req_chan_d;
    logic       req_sgl_q, req_sgl_d;
    logic       abort_q, abort_d;

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        bit_d       = bit_q;
        cmd_d       = cmd_q;
        sr_d        = sr_q;
        spi_out_d   = spi_out_q;
        spi_oe_d    = spi_oe_q;
        req_valid_d = 1'b0;
        req_chan_d  = req_chan_q;
        req_sgl_d   = req_sgl_q;
        abort_d     = 1'b0;

        if (cs_rise) begin
            state_d   = S_IDLE;
            spi_out_d = 1'b0;
            spi_oe_d  = 1'b0;
            if (state_q == S_SAMPLE || state_q == S_SHIFT ||
                (state_q == S_CMD && k_q != 3'd0)) begin
                abort_d = 1'b1;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    spi_out_d = 1'b0;
                    spi_oe_d  = 1'b0;
                    if (cs_fall) state_d = S_WAIT_START;
                end
                S_WAIT_START: begin
                    if (sclk_rise && din_p0) begin
                        state_d = S_CMD;
                        k_d     = 3'd0;
                    end
                end
                S_CMD: begin
                    if (sclk_rise) begin
                        cmd_d = {cmd_q[2:0], din_p0};
                        k_d   = k_q + 3'd1;
                        if (k_q == 3'd3) state_d = S_SAMPLE;
                    end
                end
                S_SAMPLE: begin
                    if (sclk_rise) begin
                        k_d         = k_q + 3'd1;
                        sr_d        = conv_result(adc_in, cmd_q[3], cmd_q[2:0]);
                        req_valid_d = 1'b1;
                        req_chan_d  = cmd_q[2:0];
                        req_sgl_d   = cmd_q[3];
                        bit_d       = 4'd0;
                        state_d     = S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (sclk_fall) begin
                        spi_oe_d = 1'b1;
                        if (bit_q == 4'd0) begin
                            spi_out_d = 1'b0;
                        end else begin
                            spi_out_d = sr_q[9];
                            sr_d      = {sr_q[8:0], 1'b0};
                        end
                        bit_d = bit_q + 4'd1;
                        if (bit_q == 4'd10) state_d = S_DONE;
                    end
                end
                S_DONE: begin
                    if (sclk_fall) begin
                        spi_out_d = 1'b0;
                        spi_oe_d  = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Registered control and outputs
    always_ff @(posedge CLK50) begin
        if (reset) begin
            state_q     <= S_IDLE;
            k_q         <= 3'd0;
            bit_q       <= 4'd0;
            spi_out_q   <= 1'b0;
            spi_oe_q    <= 1'b0;
            req_valid_q <= 1'b0;
            req_chan_q  <= 3'd0;
            req_sgl_q   <= 1'b0;
            abort_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            bit_q       <= bit_d;
            spi_out_q   <= spi_out_d;
            spi_oe_q    <= spi_oe_d;
            req_valid_q <= req_valid_d;
            req_chan_q  <= req_chan_d;
            req_sgl_q   <= req_sgl_d;
            abort_q     <= abort_d;
        end
    end

    always_ff @(posedge CLK50) begin
        cmd_q <= cmd_d;
        sr_q  <= sr_d;
    end

    assign spi.SPI_OUT = spi_out_q;
    assign spi.SPI_OE  = spi_oe_q;
    assign req_valid   = req_valid_q;
    assign req_chan    = req_chan_q;
    assign req_sgl     = req_sgl_q;
    assign abort       = abort_q;

endmodule

// File: tb/tb_mcp3008_responder.sv
// Bench for mcp3008_responder: an 8-channel and a 2-channel instance share one SPI master;
// frames are checked from a vector table, hand-written corner sequences and random commands.
`timescale 1ns/1ps
module tb_mcp3008_responder;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic rst;
    logic sclk, csn, mosi;
    logic [9:0] adc [0:7];
    logic [7:0][9:0] bus8;
    logic [1:0][9:0] bus2;

    always_comb begin
        for (int i = 0; i < 8; i++) bus8[i] = adc[i];
        for (int i = 0; i < 2; i++) bus2[i] = adc[i];
    end

    mcp3008_responder_if if8();
    mcp3008_responder_if if2();
    assign if8.SCLK   = sclk;
    assign if8.CS_n   = csn;
    assign if8.SPI_IN = mosi;
    assign if2.SCLK   = sclk;
    assign if2.CS_n   = csn;
    assign if2.SPI_IN = mosi;

    logic rv8, rv2, sgl8, sgl2, ab8, ab2;
    logic [2:0] ch8, ch2;

    mcp3008_responder #(.CHANNELS(8), .SYNC_STAGES(2)) dut8 (
        .CLK50(clk), .reset(rst), .spi(if8), .adc_in(bus8),
        .req_valid(rv8), .req_chan(ch8), .req_sgl(sgl8), .abort(ab8));

    mcp3008_responder #(.CHANNELS(2), .SYNC_STAGES(2)) dut2 (
        .CLK50(clk), .reset(rst), .spi(if2), .adc_in(bus2),
        .req_valid(rv2), .req_chan(ch2), .req_sgl(sgl2), .abort(ab2));

    int sel;
    logic miso, oe, rv_s, ab_s, sgl_s;
    logic [2:0] ch_s;
    logic [7:0] pack8, pack2, outs_s;

    always_comb begin
        pack8  = {if8.SPI_OUT, if8.SPI_OE, rv8, ch8, sgl8, ab8};
        pack2  = {if2.SPI_OUT, if2.SPI_OE, rv2, ch2, sgl2, ab2};
        outs_s = (sel != 0) ? pack2 : pack8;
        miso   = outs_s[7];
        oe     = outs_s[6];
        rv_s   = outs_s[5];
        ch_s   = outs_s[4:2];
        sgl_s  = outs_s[1];
        ab_s   = outs_s[0];
    end

    int rv_cnt, ab_cnt;
    logic cnt_clr;
    always @(posedge clk) begin
        if (cnt_clr) begin
            rv_cnt <= 0;
            ab_cnt <= 0;
        end else begin
            if (rv_s) rv_cnt <= rv_cnt + 1;
            if (ab_s) ab_cnt <= ab_cnt + 1;
        end
    end

    int checks = 0;
    int errors = 0;
    logic rxb [0:31];
    logic oeb [0:31];

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One SPI mode-0 frame; bit i of the frame is tx[nbits-1-i].
    task automatic xfer(input logic [31:0] tx, input int nbits, input int h,
                        input int stop_after, input int rst_at,
                        input int zap_at, input int zap_ch, input int zap_val);
        cnt_clr = 1'b1;
        step(1);
        cnt_clr = 1'b0;
        for (int i = 0; i < 32; i++) begin
            rxb[i] = 1'b0;
            oeb[i] = 1'b0;
        end
        sclk = 1'b0;
        mosi = 1'b0;
        csn  = 1'b0;
        step(h);
        for (int i = 0; i < nbits && i < stop_after; i++) begin
            if (i == rst_at) begin
                rst = 1'b1;
                step(1);
                rst = 1'b0;
                check("reset_mid_frame_outputs", int'(outs_s), 0);
                cnt_clr = 1'b1;
                step(1);
                cnt_clr = 1'b0;
            end
            mosi = tx[nbits-1-i];
            step(h);
            sclk   = 1'b1;
            rxb[i] = miso;
            oeb[i] = oe;
            step(h);
            sclk = 1'b0;
            if (i == zap_at) adc[zap_ch] = 10'(zap_val);
        end
        step(h);
        csn = 1'b1;
        step(8);
    endtask

    function automatic int find_start(input logic [31:0] tx, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            if (tx[nbits-1-i]) return i;
        end
        return 0;
    endfunction

    task automatic check_frame(input string tag, input logic [31:0] tx, input int nbits,
                               input int exp_res, input int exp_chan, input int exp_sgl);
        int s, res, oe_ok;
        s   = find_start(tx, nbits);
        res = 0;
        for (int j = 0; j < 10; j++) res = (res << 1) | int'(rxb[s+7+j]);
        oe_ok = (oeb[s+5] == 1'b0) ? 1 : 0;
        for (int j = 6; j <= 16; j++) if (oeb[s+j] != 1'b1) oe_ok = 0;
        check({tag, ".data"}, res, exp_res);
        check({tag, ".null_bit"}, int'(rxb[s+6]), 0);
        check({tag, ".oe_window"}, oe_ok, 1);
        check({tag, ".req_valid_count"}, rv_cnt, 1);
        check({tag, ".req_chan"}, int'(ch_s), exp_chan);
        check({tag, ".req_sgl"}, int'(sgl_s), exp_sgl);
        check({tag, ".abort_count"}, ab_cnt, 0);
        check({tag, ".idle_oe_out"}, int'({oe, miso}), 0);
    endtask

    // Reference: result straight from the MCP3008 channel/difference rules.
    function automatic int model(input int sgl, input int d, input int nch);
        int p, n, diff;
        if (sgl != 0) return (d < nch) ? int'(adc[d]) : 0;
        p = d;
        n = d ^ 1;
        if (p >= nch || n >= nch) return 0;
        diff = int'(adc[p]) - int'(adc[n]);
        return (diff < 0) ? 0 : diff;
    endfunction

    typedef struct {
        int       sel;
        int       h;
        logic [7:0] cmd;
        int       ia;
        int       va;
        int       ib;
        int       vb;
        int       zap;
        int       exp_res;
        int       exp_chan;
        int       exp_sgl;
    } vec_t;

    vec_t tbl [8];

    initial begin
        logic [31:0] tx;
        int n;

        tbl[0] = '{0, 128, 8'h80, 0, 'h2A5, 1, 'h000, 0, 'h2A5, 0, 1};
        tbl[1] = '{0,   8, 8'hB0, 3, 'h3FF, 0, 'h000, 1, 'h3FF, 3, 1};
        tbl[2] = '{0,   8, 8'h00, 0, 'h200, 1, 'h050, 0, 'h1B0, 0, 0};
        tbl[3] = '{0,   8, 8'h10, 0, 'h200, 1, 'h050, 0, 'h000, 1, 0};
        tbl[4] = '{1,   8, 8'hD0, 0, 'h123, 1, 'h321, 0, 'h000, 5, 1};
        tbl[5] = '{1,   8, 8'h20, 0, 'h123, 1, 'h321, 0, 'h000, 2, 0};
        tbl[6] = '{1,   7, 8'h90, 0, 'h123, 1, 'h321, 0, 'h321, 1, 1};
        tbl[7] = '{1,   6, 8'h00, 0, 'h321, 1, 'h123, 0, 'h1FE, 0, 0};

        sel = 0;
        rst = 1'b1;
        cnt_clr = 1'b1;
        sclk = 1'b0;
        csn  = 1'b1;
        mosi = 1'b0;
        for (int i = 0; i < 8; i++) adc[i] = 10'h3C3;
        step(5);
        rst = 1'b0;
        cnt_clr = 1'b0;
        step(1);
        check("reset_outputs_ch8", int'(pack8), 0);
        check("reset_outputs_ch2", int'(pack2), 0);
        step(6);

        for (int v = 0; v < 8; v++) begin
            sel = tbl[v].sel;
            for (int i = 0; i < 8; i++) adc[i] = 10'h3C3;
            adc[tbl[v].ia] = 10'(tbl[v].va);
            adc[tbl[v].ib] = 10'(tbl[v].vb);
            tx = {8'h00, 8'h01, tbl[v].cmd, 8'h00};
            xfer(tx, 24, tbl[v].h, 99, -1, (tbl[v].zap != 0) ? 14 : -1, tbl[v].ia, 0);
            check_frame($sformatf("vec%0d", v), tx, 24, tbl[v].exp_res, tbl[v].exp_chan,
                        tbl[v].exp_sgl);
        end

        // Abort after 14 rising edges (inside the shift phase), then a clean frame.
        sel = 0;
        adc[0] = 10'h155;
        tx = {8'h00, 8'h01, 8'h80, 8'h00};
        xfer(tx, 24, 7, 14, -1, -1, 0, 0);
        check("abort_shift.count", ab_cnt, 1);
        check("abort_shift.req_count", rv_cnt, 1);
        check("abort_shift.oe_out", int'({oe, miso}), 0);
        xfer(tx, 24, 7, 99, -1, -1, 0, 0);
        check_frame("after_abort", tx, 24, 'h155, 0, 1);

        // CS rise right after the start bit: no abort; one command bit later: abort.
        xfer(tx, 24, 7, 8, -1, -1, 0, 0);
        check("cs_rise_k0.abort_count", ab_cnt, 0);
        xfer(tx, 24, 7, 9, -1, -1, 0, 0);
        check("cs_rise_k1.abort_count", ab_cnt, 1);
        check("cs_rise_k1.req_count", rv_cnt, 0);

        // Reset at bit 18, trailing ones must not start a phantom command.
        adc[5] = 10'h2AA;
        adc[4] = 10'h0F3;
        tx = {8'h00, 8'h01, 8'hD0, 8'h00} | 32'h3F;
        xfer(tx, 24, 7, 99, 18, -1, 0, 0);
        n = 0;
        for (int i = 18; i < 24; i++) n += int'(oeb[i]);
        check("reset_tail.oe_bits", n, 0);
        check("reset_tail.req_count", rv_cnt, 0);
        check("reset_tail.abort_count", ab_cnt, 0);
        tx = {8'h00, 8'h01, 8'hC0, 8'h00};
        xfer(tx, 24, 7, 99, -1, -1, 0, 0);
        check_frame("post_reset", tx, 24, 'h0F3, 4, 1);
        adc[6] = 10'h1E7;
        tx = 32'h1E000;
        xfer(tx, 17, 7, 99, -1, -1, 0, 0);
        check_frame("no_lead_zero", tx, 17, 'h1E7, 6, 1);

        for (int r = 0; r < 30; r++) begin
            int sgl, d, lz, nbits, pos, h, exp, zap_at;
            sel   = int'($urandom_range(0, 1));
            for (int i = 0; i < 8; i++) adc[i] = 10'($urandom_range(0, 1023));
            sgl   = int'($urandom_range(0, 1));
            d     = int'($urandom_range(0, 7));
            lz    = int'($urandom_range(0, 7));
            nbits = lz + 17 + int'($urandom_range(0, 3));
            h     = int'($urandom_range(6, 10));
            pos   = nbits - 1 - lz;
            tx    = $urandom() & ((32'd1 << (pos - 4)) - 32'd1);
            tx    = tx | (32'({1'b1, 1'(sgl), 3'(d)}) << (pos - 4));
            exp   = model(sgl, d, (sel != 0) ? 2 : 8);
            zap_at = ($urandom_range(0, 1) != 0) ? lz + 6 : -1;
            xfer(tx, nbits, h, 99, -1, zap_at, int'($urandom_range(0, 7)),
                 int'($urandom_range(0, 1023)));
            check_frame($sformatf("rand%0d", r), tx, nbits, exp, d, sgl);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1800000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule
